// File: rtl/v_rams_stream_rd_if.sv
// Stream bundle carrying RAM words from the read sequencer to the consumer.
// Latency: none, this is a plain set of wires.
// Backpressure: ready from the slave stalls the master's current beat.
interface v_rams_stream_rd_if #(
    parameter int DATA_W = 32
) ();
    logic              valid;
    logic [DATA_W-1:0] data;
    logic              last;
    logic              ready;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/v_rams_stream_rd.sv
// Walks a run of consecutive RAM addresses and streams the words out with a last marker.
// Latency: start sampled in cycle 0, first beat valid in cycle 3, done one cycle after the final beat.
// Backpressure: a depth-3 FIFO absorbs stalls; reads stop issuing once occupancy plus in-flight reaches 3.
module v_rams_stream_rd #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base,
    input  logic [ADDR_W:0]     len,
    output logic                busy,
    output logic                done,
    input  logic                host_we,
    input  logic [ADDR_W-1:0]   host_addr,
    input  logic [DATA_W-1:0]   host_din,
    output logic                ram_we,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [DATA_W-1:0]   ram_din,
    input  logic [DATA_W-1:0]   ram_dout,
    v_rams_stream_rd_if.master  m
);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    localparam int FIFO_D = 3;
    localparam logic [ADDR_W:0]   BEAT_ONE = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q;
    logic [ADDR_W-1:0]   last_addr_q;
    logic [ADDR_W:0]     issue_left_q;
    logic [ADDR_W:0]     len_q;
    logic [ADDR_W:0]     beat_q;
    logic                inflight_q;
    logic                done_q;

    logic [DATA_W-1:0]   fifo_mem [FIFO_D];
    logic [1:0]          wr_idx_q, rd_idx_q, count_q;

    logic                issue;
    logic                load;
    logic                done_set;
    logic                push;
    logic                pop;
    logic                head_last;

    // A read issued last cycle always lands in the FIFO this cycle.
    assign push      = inflight_q;
    assign m.valid   = (count_q != 2'd0);
    assign m.data    = fifo_mem[rd_idx_q];
    assign head_last = (beat_q == (len_q - BEAT_ONE));
    assign m.last    = m.valid && head_last;
    assign pop       = m.valid && m.ready;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, RAM port steering and read-issue decision (registered occupancy only).
    always_comb begin
        state_d  = state_q;
        issue    = 1'b0;
        load     = 1'b0;
        done_set = 1'b0;
        ram_we   = 1'b0;
        ram_addr = last_addr_q;
        ram_din  = '0;
        case (state_q)
            IDLE: begin
                ram_we   = host_we;
                ram_addr = host_addr;
                ram_din  = host_din;
                if (start) begin
                    if (len == '0) begin
                        done_set = 1'b1;
                    end else begin
                        load    = 1'b1;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                ram_addr = ptr_q;
                if (({1'b0, count_q} + {2'b00, inflight_q}) <= 3'd2) begin
                    issue = 1'b1;
                    if (issue_left_q == BEAT_ONE) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (pop && head_last) begin
                    done_set = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Run bookkeeping: read pointer, issues remaining, beats emitted, done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q        <= '0;
            last_addr_q  <= '0;
            issue_left_q <= '0;
            len_q        <= '0;
            beat_q       <= '0;
            inflight_q   <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            if (load) begin
                ptr_q        <= base;
                issue_left_q <= len;
                len_q        <= len;
                beat_q       <= '0;
            end else begin
                if (issue) begin
                    ptr_q        <= ptr_q + ADDR_ONE;
                    last_addr_q  <= ptr_q;
                    issue_left_q <= issue_left_q - BEAT_ONE;
                end
                if (pop) begin
                    beat_q <= beat_q + BEAT_ONE;
                end
            end
            inflight_q <= issue;
            done_q     <= done_set;
        end
    end

    // Depth-3 output FIFO; storage is cleared so m_data reads zero after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_idx_q <= 2'd0;
            rd_idx_q <= 2'd0;
            count_q  <= 2'd0;
            for (int i = 0; i < FIFO_D; i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_mem[wr_idx_q] <= ram_dout;
                wr_idx_q           <= (wr_idx_q == 2'd2) ? 2'd0 : wr_idx_q + 2'd1;
            end
            if (pop) begin
                rd_idx_q <= (rd_idx_q == 2'd2) ? 2'd0 : rd_idx_q + 2'd1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_v_rams_stream_rd.sv
// Bench for v_rams_stream_rd: a behavioural 64x32 read-first RAM sits on the RAM port,
// and every run is checked against a word queue built from a shadow copy of the table
// (word i of a run = table[(base+i) mod 64]), with randomized bases, lengths and ready.
module tb_v_rams_stream_rd;
    localparam int AW = 6;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base;
    logic [AW:0]   len;
    logic          busy;
    logic          done;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_din;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;
    logic          ram_init;

    logic [DW-1:0] mem     [64];
    logic [DW-1:0] ref_mem [64];

    int checks = 0;
    int errors = 0;

    v_rams_stream_rd_if #(.DATA_W(DW)) m_if ();

    v_rams_stream_rd #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base      (base),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .host_we   (host_we),
        .host_addr (host_addr),
        .host_din  (host_din),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout),
        .m         (m_if)
    );

    always #5 clk = ~clk;

    // Read-first block RAM with registered output; table loaded while ram_init is high.
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h100 + 32'(i);
        end else begin
            if (ram_we) mem[ram_addr] <= ram_din;
        end
        ram_dout <= mem[ram_addr];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},     64'(busy), 64'd0);
        check({tag, "_done"},     64'(done), 64'd0);
        check({tag, "_valid"},    64'(m_if.valid), 64'd0);
        check({tag, "_last"},     64'(m_if.last), 64'd0);
        check({tag, "_data"},     64'(m_if.data), 64'd0);
        check({tag, "_ram_we"},   64'(ram_we), 64'd0);
        check({tag, "_ram_addr"}, 64'(ram_addr), 64'd0);
        check({tag, "_ram_din"},  64'(ram_din), 64'd0);
    endtask

    // One run from start to done; rnd randomizes ready, poke drives host writes while busy,
    // restart pulses start mid-run.
    task automatic run(input logic [AW-1:0] b, input int n, input bit rnd, input bit poke,
                       input bit restart);
        logic [DW-1:0] exp_q[$];
        logic [DW-1:0] pd;
        logic          pl;
        int            beat;
        bit            got_done;
        bit            stall;
        for (int i = 0; i < n; i++) exp_q.push_back(ref_mem[(int'(b) + i) % 64]);
        start = 1'b1;
        base  = b;
        len   = (AW+1)'(n);
        tick();
        start    = 1'b0;
        beat     = 0;
        got_done = 1'b0;
        stall    = 1'b0;
        pd       = '0;
        pl       = 1'b0;
        for (int c = 1; c <= 8 * n + 20; c++) begin
            if (done) begin
                host_we = 1'b0;
                check("done_beats", 64'(beat), 64'(n));
                check("done_busy", 64'(busy), 64'd0);
                if (!rnd) check("done_cycle", 64'(c), 64'(n + 3));
                got_done = 1'b1;
                break;
            end
            check("busy_run", 64'(busy), 64'd1);
            if (!rnd && c <= n) check("rd_addr", 64'(ram_addr), 64'((int'(b) + c - 1) % 64));
            if (poke) begin
                host_we   = 1'b1;
                host_addr = 6'd7;
                host_din  = 32'h1234_5678;
            end
            if (restart && c == 3) begin
                start = 1'b1;
                base  = 6'd0;
                len   = 7'd5;
            end else begin
                start = 1'b0;
            end
            m_if.ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (poke) check("ram_we_busy", 64'(ram_we), 64'd0);
            if (stall) begin
                check("hold_data", 64'(m_if.data), 64'(pd));
                check("hold_last", 64'(m_if.last), 64'(pl));
            end
            stall = m_if.valid && !m_if.ready;
            pd    = m_if.data;
            pl    = m_if.last;
            if (m_if.valid && m_if.ready) begin
                check("beat_in_range", 64'(beat < n), 64'd1);
                if (beat < n) begin
                    check("beat_data", 64'(m_if.data), 64'(exp_q[beat]));
                    check("beat_last", 64'(m_if.last), 64'(beat == n - 1));
                end
                if (!rnd) check("beat_cycle", 64'(c), 64'(beat + 3));
                beat++;
            end
            tick();
        end
        host_we    = 1'b0;
        host_addr  = '0;
        host_din   = '0;
        start      = 1'b0;
        m_if.ready = 1'b0;
        check("run_finished", 64'(got_done), 64'd1);
        tick();
        check("done_one_cycle", 64'(done), 64'd0);
        check("idle_no_valid", 64'(m_if.valid), 64'd0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) ref_mem[i] = 32'h100 + 32'(i);
        rst        = 1'b1;
        ram_init   = 1'b1;
        start      = 1'b0;
        base       = '0;
        len        = '0;
        host_we    = 1'b0;
        host_addr  = '0;
        host_din   = '0;
        m_if.ready = 1'b0;
        tick();
        ram_init = 1'b0;
        tick();
        check_reset_outputs("por");
        rst = 1'b0;
        tick();

        // Basic run, then address wrap past 63.
        run(6'd0, 4, 1'b0, 1'b0, 1'b0);
        run(6'd62, 4, 1'b0, 1'b0, 1'b0);

        // Backpressure with random ready.
        run(6'($urandom_range(0, 63)), 20, 1'b1, 1'b0, 1'b0);

        // Zero-length command: done next cycle, never busy.
        start = 1'b1;
        base  = 6'd3;
        len   = 7'd0;
        tick();
        start = 1'b0;
        check("len0_done", 64'(done), 64'd1);
        check("len0_busy", 64'(busy), 64'd0);
        check("len0_valid", 64'(m_if.valid), 64'd0);
        tick();
        check("len0_done_clear", 64'(done), 64'd0);
        check("len0_still_idle", 64'(busy), 64'd0);

        // start pulsed mid-run must not trigger a second run.
        run(6'd9, 6, 1'b0, 1'b0, 1'b1);
        repeat (3) begin
            tick();
            check("no_second_run", 64'(busy), 64'd0);
        end

        // Host write passes straight through to the RAM in IDLE.
        host_we   = 1'b1;
        host_addr = 6'd5;
        host_din  = 32'hDEAD_BEEF;
        #1;
        check("host_we_pass", 64'(ram_we), 64'd1);
        check("host_addr_pass", 64'(ram_addr), 64'd5);
        check("host_din_pass", 64'(ram_din), 64'hDEAD_BEEF);
        tick();
        host_we    = 1'b0;
        host_addr  = '0;
        host_din   = '0;
        ref_mem[5] = 32'hDEAD_BEEF;
        run(6'd5, 1, 1'b0, 1'b0, 1'b0);

        // Host writes while busy are dropped; word 7 keeps its contents.
        run(6'd20, 8, 1'b1, 1'b1, 1'b0);
        run(6'd7, 1, 1'b0, 1'b0, 1'b0);

        // Reset mid-run with data waiting in the FIFO.
        start = 1'b1;
        base  = 6'd10;
        len   = 7'd30;
        tick();
        start      = 1'b0;
        m_if.ready = 1'b0;
        repeat (4) tick();
        check("pre_rst_valid", 64'(m_if.valid), 64'd1);
        rst = 1'b1;
        tick();
        check_reset_outputs("mid_rst");
        tick();
        rst = 1'b0;
        check_reset_outputs("mid_rst2");
        repeat (4) begin
            tick();
            check("post_rst_done", 64'(done), 64'd0);
            check("post_rst_valid", 64'(m_if.valid), 64'd0);
            check("post_rst_busy", 64'(busy), 64'd0);
        end
        run(6'd0, 2, 1'b0, 1'b0, 1'b0);

        // Random runs, including lengths beyond 64 that repeat addresses.
        repeat (6) begin
            run(6'($urandom_range(0, 63)), int'($urandom_range(1, 127)), 1'b1, 1'b0, 1'b0);
        end
        run(6'd40, 127, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
